// File: rtl/asteroid_scheduler.sv
// asteroid_scheduler: game FSM that spawns asteroids into three slots,
// paces movement ticks and picks per-slot speeds from an 8-bit LFSR.
module asteroid_scheduler #(
    parameter int SPAWN_GAP = 5000000,
    parameter int TICK_DIV  = 251250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       halt,
    input  logic       collision,
    input  logic [2:0] slot_done,
    output logic [2:0] asteroid_on,
    output logic [5:0] speed_sel,
    output logic       move_tick,
    output logic [1:0] active_count,
    output logic [7:0] spawn_count,
    output logic [1:0] state
);

    localparam int GW = $clog2(SPAWN_GAP + 1);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(SPAWN_GAP - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t cur;
    state_t nxt;

    logic [GW-1:0] gap;
    logic [TW-1:0] tick;
    logic [7:0]    lfsr;
    logic          fb;

    logic          run;
    logic          enter_run;
    logic          clear;
    logic          gap_full;
    logic          spawn_ok;
    logic [2:0]    free;
    logic [2:0]    pick;
    logic [2:0]    on_next;
    logic [5:0]    spd_next;
    logic [1:0]    spd;

    function automatic logic [1:0] ones(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    always_comb begin
        nxt = cur;
        unique case (cur)
            IDLE:  if (start) nxt = RUN;
            RUN: begin
                if (collision)
                    nxt = OVER;
                else if (halt)
                    nxt = PAUSE;
            end
            PAUSE: if (!halt) nxt = RUN;
            OVER:  if (start) nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cur <= IDLE;
        else
            cur <= nxt;
    end

    assign state     = cur;
    assign run       = (cur == RUN);
    assign enter_run = (cur == IDLE) && (nxt == RUN);
    assign clear     = (cur == OVER) && (nxt == IDLE);
    assign move_tick = run && (tick == TICK_LAST);

    // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0
    assign fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign spd = (lfsr[1:0] == 2'b11) ? 2'b10 : lfsr[1:0];

    // a slot finishing this cycle only becomes spawnable next cycle
    assign free     = ~asteroid_on & ~slot_done;
    assign gap_full = (gap == GAP_LAST);
    assign spawn_ok = run && gap_full && (|free);
    assign pick     = spawn_ok ? (free & (~free + 3'd1)) : 3'd0;
    assign on_next  = (asteroid_on & ~slot_done) | pick;

    always_comb begin
        spd_next = speed_sel;
        unique case (1'b1)
            pick[0]: spd_next[1:0] = spd;
            pick[1]: spd_next[3:2] = spd;
            pick[2]: spd_next[5:4] = spd;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr         <= 8'hA5;
            asteroid_on  <= '0;
            speed_sel    <= '0;
            active_count <= '0;
            spawn_count  <= '0;
            gap          <= '0;
            tick         <= '0;
        end else begin
            lfsr <= {lfsr[6:0], fb};
            if (clear) begin
                asteroid_on  <= '0;
                speed_sel    <= '0;
                active_count <= '0;
                spawn_count  <= '0;
                gap          <= '0;
                tick         <= '0;
            end else if (run) begin
                asteroid_on  <= on_next;
                speed_sel    <= spd_next;
                active_count <= ones(on_next);
                if (spawn_ok && (spawn_count != 8'hFF))
                    spawn_count <= spawn_count + 8'd1;
                if (spawn_ok)
                    gap <= '0;
                else if (!gap_full)
                    gap <= gap + GW'(1);
                if (tick == TICK_LAST)
                    tick <= '0;
                else
                    tick <= tick + TW'(1);
            end else if (enter_run) begin
                gap <= GAP_LAST;
            end
        end
    end

endmodule

// File: tb/tb_asteroid_scheduler.sv
// Directed bench for asteroid_scheduler with a cycle model checked
// on every falling edge plus hand-computed literal expectations.
module tb_asteroid_scheduler;

    localparam int SG = 4;
    localparam int TD = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       halt;
    logic       collision;
    logic [2:0] slot_done;
    logic [2:0] asteroid_on;
    logic [5:0] speed_sel;
    logic       move_tick;
    logic [1:0] active_count;
    logic [7:0] spawn_count;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    asteroid_scheduler #(.SPAWN_GAP(SG), .TICK_DIV(TD)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .halt(halt),
        .collision(collision),
        .slot_done(slot_done),
        .asteroid_on(asteroid_on),
        .speed_sel(speed_sel),
        .move_tick(move_tick),
        .active_count(active_count),
        .spawn_count(spawn_count),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: states 0 idle, 1 run, 2 pause, 3 over
    int         m_st = 0;
    logic       m_on [3] = '{0, 0, 0};
    logic [1:0] m_spd[3] = '{0, 0, 0};
    int         m_gap = 0;
    int         m_tick = 0;
    int         m_cnt = 0;
    int         m_total = 0;
    logic [7:0] m_lfsr = 8'hA5;
    int         nst;
    int         pk;
    logic       seen3 = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_st = 0;
            for (int i = 0; i < 3; i++) begin
                m_on[i] = 1'b0;
                m_spd[i] = 2'd0;
            end
            m_gap = 0;
            m_tick = 0;
            m_cnt = 0;
            m_lfsr = 8'hA5;
        end else begin
            nst = m_st;
            case (m_st)
                0: if (start) nst = 1;
                1: if (collision) nst = 3;
                   else if (halt) nst = 2;
                2: if (!halt) nst = 1;
                3: if (start) nst = 0;
                default: nst = 0;
            endcase
            if (m_st == 1) begin
                pk = -1;
                if (m_gap == SG - 1)
                    for (int i = 2; i >= 0; i--)
                        if (!m_on[i] && !slot_done[i]) pk = i;
                for (int i = 0; i < 3; i++)
                    if (slot_done[i]) m_on[i] = 1'b0;
                if (pk >= 0) begin
                    m_on[pk] = 1'b1;
                    m_spd[pk] = (m_lfsr[1:0] == 2'd3)
                              ? 2'd2 : m_lfsr[1:0];
                    m_gap = 0;
                    if (m_cnt < 255) m_cnt++;
                    m_total++;
                end else if (m_gap < SG - 1) begin
                    m_gap++;
                end
                m_tick = (m_tick == TD - 1) ? 0 : m_tick + 1;
            end
            if (m_st == 0 && nst == 1) m_gap = SG - 1;
            if (m_st == 3 && nst == 0) begin
                for (int i = 0; i < 3; i++) begin
                    m_on[i] = 1'b0;
                    m_spd[i] = 2'd0;
                end
                m_gap = 0;
                m_tick = 0;
                m_cnt = 0;
            end
            m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};
            m_st = nst;
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("state", 32'(state), 32'(m_st));
            chk("asteroid_on", 32'(asteroid_on),
                32'({m_on[2], m_on[1], m_on[0]}));
            chk("speed_sel", 32'(speed_sel),
                32'({m_spd[2], m_spd[1], m_spd[0]}));
            chk("move_tick", 32'(move_tick),
                32'(m_st == 1 && m_tick == TD - 1));
            chk("active_count", 32'(active_count),
                32'(int'(m_on[0]) + int'(m_on[1]) + int'(m_on[2])));
            chk("spawn_count", 32'(spawn_count), 32'(m_cnt));
            for (int i = 0; i < 3; i++)
                if (speed_sel[2*i +: 2] == 2'd3) seen3 = 1'b1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic begin_game();
        reset = 1'b1;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_on"}, 32'(asteroid_on), 0);
        chk({tag, "_spd"}, 32'(speed_sel), 0);
        chk({tag, "_tick"}, 32'(move_tick), 0);
        chk({tag, "_act"}, 32'(active_count), 0);
        chk({tag, "_cnt"}, 32'(spawn_count), 0);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        start = 1'b0;
        halt = 1'b0;
        collision = 1'b0;
        slot_done = 3'b000;
        repeat (3) @(posedge clk);
        #2;
        chk_zero("rst");

        begin_game();
        chk("run_c1", 32'(state), 1);
        cyc(1);
        chk("on_c2", 32'(asteroid_on), 32'(3'b001));
        chk("spd_c2", 32'(speed_sel), 32'(6'b000010));
        chk("tick_c2", 32'(move_tick), 0);
        cyc(1);
        chk("tick_c3", 32'(move_tick), 1);
        cyc(3);
        chk("on_c6", 32'(asteroid_on), 32'(3'b011));
        chk("spd_c6", 32'(speed_sel), 32'(6'b000110));
        chk("tick_c6", 32'(move_tick), 1);
        cyc(4);
        chk("on_c10", 32'(asteroid_on), 32'(3'b111));
        chk("act_c10", 32'(active_count), 3);

        cyc(10);
        slot_done = 3'b010;
        cyc(1);
        slot_done = 3'b000;
        chk("drain_c21", 32'(asteroid_on), 32'(3'b101));
        chk("act_c21", 32'(active_count), 2);
        cyc(1);
        chk("respawn_c22", 32'(asteroid_on), 32'(3'b111));
        chk("cnt_c22", 32'(spawn_count), 4);

        halt = 1'b1;
        cyc(1);
        chk("pause", 32'(state), 2);
        cyc(9);
        chk("pause_hold", 32'(state), 2);
        chk("pause_cnt", 32'(spawn_count), 4);
        chk("pause_on", 32'(asteroid_on), 32'(3'b111));
        halt = 1'b0;
        cyc(1);
        chk("resume", 32'(state), 1);
        cyc(2);

        collision = 1'b1;
        halt = 1'b1;
        cyc(1);
        collision = 1'b0;
        halt = 1'b0;
        chk("over", 32'(state), 3);
        cyc(2);
        chk("over_hold", 32'(state), 3);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk_zero("idle");

        begin_game();
        cyc(5);
        chk("on_pre_rst", 32'(asteroid_on), 32'(3'b011));
        #1;
        reset = 1'b0;
        #1;
        chk_zero("async");
        cyc(2);
        begin_game();
        cyc(1);
        chk("reseed_on", 32'(asteroid_on), 32'(3'b001));
        chk("reseed_spd", 32'(speed_sel), 32'(6'b000010));

        m_total = 0;
        n = 0;
        while (m_total < 300 && n < 6000) begin
            slot_done = 3'(3'b001 << (n % 3));
            cyc(1);
            n++;
        end
        slot_done = 3'b000;
        cyc(1);
        chk("spawn_bound", 32'(m_total >= 300), 1);
        chk("spawn_sat", 32'(spawn_count), 255);
        chk("no_speed3", 32'(seen3), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
